instr_decode: RTL and testbench
===============================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL be clocked by one clock and use a reset that is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr  in  16  fetched instruction: op[15:12], rd[11:7], rs[6:2], imm[6:0].
REQ-005 instr_valid  in  1  instr/npc_in are valid this cycle.
REQ-006 npc_in  in  16  PC+1 of instr.
REQ-007 flush  in  1  taken branch; discard the instruction being decoded.
REQ-008 wb_en / wb_index / wb_data  in  1/5/16  register-file write port from writeback.
REQ-009 control_in, dest_index_in  out  5/5  Execute opcode {1'b0,op} and rd.
REQ-010 reg1_data, reg2_data  out  16/16  R[rd] and R[rs] operands.
REQ-011 npc, immediate  out  16/7  forwarded npc_in and imm[6:0].
REQ-012 reg_write_en  out  1  the decoded instruction writes rd.
REQ-013 stall_out  in->out  1  combinational; upstream SHALL hold instr/npc_in while 1.

Function
REQ-014 Opcodes: NOP 0, SUB 1, ADD 2, ADDI 3, SHLLI 4, SHRLI 5, JUMP 6, JUMPL 7, JUMPG 8, JUMPE 9, JUMPNE A, CMP B, LOAD C, LOADI D, STORE E, MOV F.
REQ-015 Register file: 32 x 16 bits; R0 SHALL read 0; writes to R0 SHALL be ignored.
REQ-016 Writes SHALL occur on the rising edge when wb_en=1.
REQ-017 A read of index == wb_index with wb_en=1 in the same cycle SHALL return wb_data (write-through bypass).
REQ-018 All outputs except stall_out SHALL be registered; latency SHALL be one cycle from instr to outputs.
REQ-019 Source usage: SUB, ADD, CMP, STORE read rd and rs; ADDI, SHLLI, SHRLI read rd; MOV and LOAD read rs; NOP, LOADI and JUMP* read none.
REQ-020 reg_write_en SHALL be 1 for SUB, ADD, ADDI, SHLLI, SHRLI, LOAD, LOADI, MOV; it SHALL be 0 otherwise.
REQ-021 Load-use hazard: stall_out SHALL be 1 when control_in==LOAD, reg_write_en=1, instr_valid=1, and the current instr reads a register equal to dest_index_in (R0 excluded).
REQ-022 When stall_out=1, the next edge SHALL load a bubble and stall_out SHALL clear the following cycle.
REQ-023 A bubble SHALL be: control_in=0, dest_index_in=0, reg_write_en=0, reg1/reg2/npc/immediate=0.
REQ-024 instr_valid=0 SHALL load a bubble on the next edge.
REQ-025 flush=1 SHALL load a bubble on the next edge and force stall_out=0; flush has priority over stall and valid.
REQ-026 The register-file write SHALL proceed during stall, flush and bubble cycles.
REQ-027 Fields SHALL be passed unmodified (no sign extension); Execute owns immediate interpretation.

Reset
REQ-028 While rst_n=0, all registered outputs SHALL be 0 (bubble), stall_out SHALL be 0, and all 32 registers SHALL be 0.
REQ-029 Reset assertion mid-stall SHALL immediately clear outputs and stall_out.
REQ-030 After deassertion, the first edge with instr_valid=1 SHALL decode normally.

Verification
REQ-031 Write R1=10 and R3=3 via wb, then SUB rd=1 rs=3 -> next cycle control_in=1, dest_index_in=1, reg1_data=10, reg2_data=3, reg_write_en=1.
REQ-032 ADDI rd=2 imm=7 while wb writes R2=5 in the same cycle -> reg1_data=5 (bypass), immediate=7.
REQ-033 LOAD rd=4, then ADD rd=4 rs=5 -> stall_out=1 for one cycle; bubble output; then ADD is issued with stall_out=0.
REQ-034 JUMPL imm=1 with npc_in=5 and flush=1 in the same cycle -> next cycle all outputs 0, reg_write_en=0.
REQ-035 wb write of R0=0xFFFF, then MOV rs=0 -> reg2_data=0.
REQ-036 Assert rst_n=0 asynchronously during a stall -> outputs and stall_out are 0 before the next clk edge, and registers read back 0.

Source files
------------

// File: rtl/instr_decode.sv
// Decode stage: register file with write-through bypass, operand fetch,
// load-use hazard detection and a one-cycle registered decode bundle.
module instr_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   input  logic [15:0] npc_in,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_index,
   input  logic [15:0] wb_data,
   output logic [4:0]  control_in,
   output logic [4:0]  dest_index_in,
   output logic [15:0] reg1_data,
   output logic [15:0] reg2_data,
   output logic [15:0] npc,
   output logic [6:0]  immediate,
   output logic        reg_write_en,
   output logic        stall_out
);

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_ADDI  = 4'h3;
   localparam logic [3:0] OP_SHLLI = 4'h4;
   localparam logic [3:0] OP_SHRLI = 4'h5;
   localparam logic [3:0] OP_CMP   = 4'hB;
   localparam logic [3:0] OP_LOAD  = 4'hC;
   localparam logic [3:0] OP_LOADI = 4'hD;
   localparam logic [3:0] OP_STORE = 4'hE;
   localparam logic [3:0] OP_MOV   = 4'hF;

   logic [15:0] rf_q [32];

   logic [3:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs;
   logic        use_rd;
   logic        use_rs;
   logic        wr_rd;
   logic        is_rr;
   logic        is_ri;
   logic        is_rs;
   logic [15:0] rd_val;
   logic [15:0] rs_val;
   logic        bubble;

   logic [4:0]  ctrl_q, ctrl_d;
   logic [4:0]  dest_q, dest_d;
   logic [15:0] r1_q, r1_d;
   logic [15:0] r2_q, r2_d;
   logic [15:0] npc_q, npc_d;
   logic [6:0]  imm_q, imm_d;
   logic        we_q, we_d;

   assign op = instr[15:12];
   assign rd = instr[11:7];
   assign rs = instr[6:2];

   assign is_rr = (op == OP_SUB) || (op == OP_ADD) ||
                  (op == OP_CMP) || (op == OP_STORE);
   assign is_ri = (op == OP_ADDI) || (op == OP_SHLLI) ||
                  (op == OP_SHRLI);
   assign is_rs = (op == OP_MOV) || (op == OP_LOAD);

   // Classify which source fields the opcode actually reads
   always_comb begin
      use_rd = 1'b0;
      use_rs = 1'b0;
      unique case (1'b1)
         is_rr: begin
            use_rd = 1'b1;
            use_rs = 1'b1;
         end
         is_ri: use_rd = 1'b1;
         is_rs: use_rs = 1'b1;
         default: ;
      endcase
   end

   // Opcodes that produce a result into rd
   always_comb begin
      wr_rd = 1'b0;
      unique case (1'b1)
         is_rr: wr_rd = (op == OP_SUB) || (op == OP_ADD);
         is_ri: wr_rd = 1'b1;
         is_rs: wr_rd = 1'b1;
         default: wr_rd = (op == OP_LOADI);
      endcase
   end

   // Register reads with R0 hardwired and same-cycle writeback bypass
   always_comb begin
      rd_val = '0;
      rs_val = '0;
      if (rd != 5'd0)
         rd_val = (wb_en && wb_index == rd) ? wb_data : rf_q[rd];
      if (rs != 5'd0)
         rs_val = (wb_en && wb_index == rs) ? wb_data : rf_q[rs];
   end

   // Load-use hazard against the load currently held in the output stage
   always_comb begin
      stall_out = 1'b0;
      if (!flush && instr_valid && we_q && dest_q != 5'd0 &&
          ctrl_q == {1'b0, OP_LOAD})
         stall_out = (use_rd && rd == dest_q) ||
                     (use_rs && rs == dest_q);
   end

   assign bubble = flush || stall_out || !instr_valid;

   // Next decode bundle, or an all-zero bubble
   always_comb begin
      ctrl_d = '0;
      dest_d = '0;
      r1_d   = '0;
      r2_d   = '0;
      npc_d  = '0;
      imm_d  = '0;
      we_d   = 1'b0;
      if (!bubble) begin
         ctrl_d = {1'b0, op};
         dest_d = rd;
         r1_d   = use_rd ? rd_val : 16'h0000;
         r2_d   = use_rs ? rs_val : 16'h0000;
         npc_d  = npc_in;
         imm_d  = instr[6:0];
         we_d   = wr_rd;
      end
   end

   // Decode output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         dest_q <= '0;
         r1_q   <= '0;
         r2_q   <= '0;
         npc_q  <= '0;
         imm_q  <= '0;
         we_q   <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         dest_q <= dest_d;
         r1_q   <= r1_d;
         r2_q   <= r2_d;
         npc_q  <= npc_d;
         imm_q  <= imm_d;
         we_q   <= we_d;
      end
   end

   // Register file writes continue regardless of stall or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            rf_q[i] <= '0;
      end else if (wb_en && wb_index != 5'd0) begin
         rf_q[wb_index] <= wb_data;
      end
   end

   assign control_in    = ctrl_q;
   assign dest_index_in = dest_q;
   assign reg1_data     = r1_q;
   assign reg2_data     = r2_q;
   assign npc           = npc_q;
   assign immediate     = imm_q;
   assign reg_write_en  = we_q;

   logic unused_ok;
   assign unused_ok = ^{OP_NOP, OP_LOADI};

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with an opcode-table reference model.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] npc_in;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_index;
   logic [15:0] wb_data;
   logic [4:0]  control_in;
   logic [4:0]  dest_index_in;
   logic [15:0] reg1_data;
   logic [15:0] reg2_data;
   logic [15:0] npc;
   logic [6:0]  immediate;
   logic        reg_write_en;
   logic        stall_out;

   int checks = 0;
   int errors = 0;

   instr_decode dut (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .instr_valid(instr_valid), .npc_in(npc_in), .flush(flush),
      .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
      .control_in(control_in), .dest_index_in(dest_index_in),
      .reg1_data(reg1_data), .reg2_data(reg2_data), .npc(npc),
      .immediate(immediate), .reg_write_en(reg_write_en),
      .stall_out(stall_out)
   );

   always #5 clk = ~clk;

   // opcode property tables, bit n = opcode n
   logic [15:0] rd_mask = 16'h483E;
   logic [15:0] rs_mask = 16'hD806;
   logic [15:0] we_mask = 16'hB03E;

   logic [15:0] mreg [32];
   logic [4:0]  e_ctrl;
   logic [4:0]  e_dest;
   logic [15:0] e_r1, e_r2, e_npc;
   logic [6:0]  e_imm;
   logic        e_we;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic model_stall();
      logic [3:0] o;
      logic       hit;
      o = instr[15:12];
      hit = (rd_mask[o] && instr[11:7] == e_dest) ||
            (rs_mask[o] && instr[6:2] == e_dest);
      return rst_n && !flush && instr_valid && e_ctrl == 5'd12 &&
             e_we && e_dest != 5'd0 && hit;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      e_ctrl = '0; e_dest = '0; e_r1 = '0; e_r2 = '0;
      e_npc = '0; e_imm = '0; e_we = 1'b0;
   endtask

   initial model_clear();

   // reference: apply writeback first (write-through), then decode
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_clear();
      end else begin
         logic st;
         logic [3:0] o;
         st = model_stall();
         o = instr[15:12];
         if (wb_en) mreg[wb_index] = wb_data;
         mreg[0] = '0;
         if (flush || st || !instr_valid) begin
            e_ctrl = '0; e_dest = '0; e_r1 = '0; e_r2 = '0;
            e_npc = '0; e_imm = '0; e_we = 1'b0;
         end else begin
            e_ctrl = {1'b0, o};
            e_dest = instr[11:7];
            e_r1 = rd_mask[o] ? mreg[instr[11:7]] : 16'h0;
            e_r2 = rs_mask[o] ? mreg[instr[6:2]] : 16'h0;
            e_npc = npc_in;
            e_imm = instr[6:0];
            e_we = we_mask[o];
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if ($time > 2) begin
         chk("m_ctrl", 32'(control_in), 32'(e_ctrl));
         chk("m_dest", 32'(dest_index_in), 32'(e_dest));
         chk("m_r1", 32'(reg1_data), 32'(e_r1));
         chk("m_r2", 32'(reg2_data), 32'(e_r2));
         chk("m_npc", 32'(npc), 32'(e_npc));
         chk("m_imm", 32'(immediate), 32'(e_imm));
         chk("m_we", 32'(reg_write_en), 32'(e_we));
         chk("m_stall", 32'(stall_out), 32'(model_stall()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] i, input logic [15:0] d);
      wb_en = 1'b1; wb_index = i; wb_data = d;
      tick();
   endtask

   initial begin
      rst_n = 1'b1; instr = '0; instr_valid = 1'b0; npc_in = '0;
      flush = 1'b0; wb_en = 1'b0; wb_index = '0; wb_data = '0;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_ctrl", 32'(control_in), 32'h0);
      chk("rst_stall", 32'(stall_out), 32'h0);
      rst_n = 1'b1;

      wb(5'd1, 16'd10);
      wb(5'd3, 16'd3);
      wb(5'd4, 16'h0044);
      wb(5'd5, 16'h0055);
      wb_en = 1'b0;

      // SUB rd=1 rs=3
      instr = 16'h108C; instr_valid = 1'b1; npc_in = 16'h0011;
      tick();
      chk("sub_ctrl", 32'(control_in), 32'd1);
      chk("sub_dest", 32'(dest_index_in), 32'd1);
      chk("sub_r1", 32'(reg1_data), 32'd10);
      chk("sub_r2", 32'(reg2_data), 32'd3);
      chk("sub_we", 32'(reg_write_en), 32'd1);

      // ADDI rd=2 imm=7 with same-cycle writeback of R2
      instr = 16'h3107; wb_en = 1'b1; wb_index = 5'd2; wb_data = 16'd5;
      tick();
      wb_en = 1'b0;
      chk("addi_r1", 32'(reg1_data), 32'd5);
      chk("addi_imm", 32'(immediate), 32'd7);

      // LOAD rd=4 then ADD rd=4 rs=5
      instr = 16'hC218;
      tick();
      chk("ld_ctrl", 32'(control_in), 32'd12);
      instr = 16'h2214;
      #1 chk("lu_stall", 32'(stall_out), 32'd1);
      tick();
      chk("lu_bubble", 32'(control_in), 32'd0);
      chk("lu_bub_we", 32'(reg_write_en), 32'd0);
      chk("lu_clear", 32'(stall_out), 32'd0);
      tick();
      chk("add_ctrl", 32'(control_in), 32'd2);
      chk("add_r2", 32'(reg2_data), 32'h55);

      // flush beats stall
      instr = 16'hC218;
      tick();
      instr = 16'h2214; flush = 1'b1;
      #1 chk("fl_stall", 32'(stall_out), 32'd0);
      tick();
      chk("fl_ctrl", 32'(control_in), 32'd0);

      // JUMPL with flush
      instr = 16'h7001; npc_in = 16'd5; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("jl_npc", 32'(npc), 32'd0);
      chk("jl_imm", 32'(immediate), 32'd0);

      // invalid slot
      instr = 16'h108C; instr_valid = 1'b0;
      tick();
      chk("inv_ctrl", 32'(control_in), 32'd0);
      instr_valid = 1'b1;

      // R0 write ignored, then MOV rd=6 rs=0 (bypass must not apply)
      wb(5'd0, 16'hFFFF);
      instr = 16'hF300;
      tick();
      wb_en = 1'b0;
      chk("mov_r2", 32'(reg2_data), 32'd0);
      chk("mov_we", 32'(reg_write_en), 32'd1);

      // reset in the middle of a stall
      instr = 16'hC218;
      tick();
      instr = 16'h2214;
      #1 chk("rs_stall", 32'(stall_out), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_stall", 32'(stall_out), 32'd0);
      chk("ar_ctrl", 32'(control_in), 32'd0);
      chk("ar_dest", 32'(dest_index_in), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("pr_ctrl", 32'(control_in), 32'd2);
      chk("pr_r1", 32'(reg1_data), 32'd0);
      chk("pr_r2", 32'(reg2_data), 32'd0);
      instr_valid = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
